// File: rtl/coin_acceptor_frontend_if.sv
// Sensor/controller bundle of the coin acceptor front end.
// master = sensors + vending controller side, slave = the front end itself.
interface coin_acceptor_frontend_if #(
   parameter int DEPTH = 4
);
   logic                     coin5_raw;
   logic                     coin10_raw;
   logic [1:0]               coin_out;
   logic                     burst_active;
   logic                     reject;
   logic [$clog2(DEPTH):0]   fifo_count;

   modport master (
      output coin5_raw, coin10_raw,
      input  coin_out, burst_active, reject, fifo_count
   );

   modport slave (
      input  coin5_raw, coin10_raw,
      output coin_out, burst_active, reject, fifo_count
   );
endinterface

// File: rtl/coin_acceptor_frontend.sv
// Coin acceptor front end: synchronize/debounce two coin sensors, collect coins
// into a transaction and release it contiguously with one 00 terminator cycle.
module coin_acceptor_frontend #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int WINDOW_CYC   = 16,
   parameter int DEPTH        = 4
) (
   input logic                      clk,
   input logic                      rst,
   coin_acceptor_frontend_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam int TW = $clog2(WINDOW_CYC);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(WINDOW_CYC - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_RELEASE = 2'd2,
      S_GAP     = 2'd3
   } state_t;

   // Channel bit 0 is 5 rs, bit 1 is 10 rs; the bit pattern doubles as coin code and value.
   logic [1:0]    r_meta, r_sync, r_deb, r_deb_d;
   logic [DW-1:0] r_dcnt [2];

   state_t        r_state;
   logic [TW-1:0] r_tmr;
   logic [1:0]    r_acc;
   logic [1:0]    r_fifo [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic [1:0]    r_coin_out;
   logic          r_burst;
   logic          r_reject;

   logic [1:0]    w_ev;
   logic          w_any, w_both, w_full, w_accept, w_push;
   logic [2:0]    w_acc_sum;
   logic [1:0]    w_acc_next;
   logic [TW-1:0] w_tmr_inc;

   // Two-flop synchronizer followed by a stable-count debouncer per channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta    <= 2'b00;
         r_sync    <= 2'b00;
         r_deb     <= 2'b00;
         r_deb_d   <= 2'b00;
         r_dcnt[0] <= '0;
         r_dcnt[1] <= '0;
      end else begin
         r_meta  <= {bus.coin10_raw, bus.coin5_raw};
         r_sync  <= r_meta;
         r_deb_d <= r_deb;
         for (int i = 0; i < 2; i++) begin
            if (r_sync[i] == r_deb[i]) begin
               r_dcnt[i] <= '0;
            end else if (r_dcnt[i] == DEB_LAST) begin
               r_deb[i]  <= r_sync[i];
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + DW'(1);
            end
         end
      end
   end

   // Event decode, accumulator saturation and push qualification.
   always_comb begin
      w_ev      = r_deb & ~r_deb_d;
      w_any     = |w_ev;
      w_both    = &w_ev;
      w_full    = (r_count == FULL_CNT);
      w_accept  = w_any & ~w_both & ~w_full;
      w_push    = w_accept & ((r_state == S_IDLE) | (r_state == S_COLLECT));
      w_acc_sum = {1'b0, r_acc} + {1'b0, w_ev};
      w_tmr_inc = r_tmr + TW'(1);
      if (w_acc_sum > 3'd3) begin
         w_acc_next = 2'd3;
      end else begin
         w_acc_next = w_acc_sum[1:0];
      end
   end

   // FIFO storage; no reset needed since occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr] <= w_ev;
      end
   end

   // Transaction FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tmr      <= '0;
         r_acc      <= 2'd0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_coin_out <= 2'b00;
         r_burst    <= 1'b0;
         r_reject   <= 1'b0;
      end else begin
         r_coin_out <= 2'b00;
         r_burst    <= 1'b0;
         r_reject   <= 1'b0;
         if (w_push) begin
            r_wr    <= r_wr + AW'(1);
            r_count <= r_count + CW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (w_push) begin
                  r_tmr   <= '0;
                  r_acc   <= w_ev;
                  r_state <= S_COLLECT;
               end else if (w_any) begin
                  r_reject <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (w_push) begin
                  r_tmr <= '0;
                  r_acc <= w_acc_next;
                  if (w_acc_next == 2'd3) begin
                     r_state <= S_RELEASE;
                  end
               end else begin
                  r_reject <= w_any;
                  r_tmr    <= w_tmr_inc;
                  if (w_tmr_inc == TMR_LAST) begin
                     r_state <= S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               r_burst  <= 1'b1;
               r_reject <= w_any;
               if (r_count != CW'(0)) begin
                  r_coin_out <= r_fifo[r_rd];
                  r_rd       <= r_rd + AW'(1);
                  r_count    <= r_count - CW'(1);
               end
               if (r_count <= CW'(1)) begin
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               r_burst  <= 1'b1;
               r_reject <= w_any;
               r_acc    <= 2'd0;
               r_tmr    <= '0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.coin_out     = r_coin_out;
   assign bus.burst_active = r_burst;
   assign bus.reject       = r_reject;
   assign bus.fifo_count   = r_count;
endmodule

// File: tb/tb_coin_acceptor_frontend.sv
// Directed self-checking bench for coin_acceptor_frontend (default parameters).
module tb_coin_acceptor_frontend;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   coin_acceptor_frontend_if #(.DEPTH(4)) bus ();

   coin_acceptor_frontend #(
      .DEBOUNCE_CYC (4),
      .WINDOW_CYC   (16),
      .DEPTH        (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] co();
      return {6'd0, bus.coin_out};
   endfunction
   function automatic logic [7:0] ba();
      return {7'd0, bus.burst_active};
   endfunction
   function automatic logic [7:0] rj();
      return {7'd0, bus.reject};
   endfunction
   function automatic logic [7:0] fc();
      return {5'd0, bus.fifo_count};
   endfunction

   initial begin
      bus.coin5_raw  = 1'b0;
      bus.coin10_raw = 1'b0;
      cyc(3);
      chk("rst_coin_out", co(), 8'h00);
      chk("rst_burst", ba(), 8'h00);
      chk("rst_reject", rj(), 8'h00);
      chk("rst_fifo_count", fc(), 8'h00);
      rst = 1'b0;
      cyc(2);

      // Single 5 rs, 10 cycles wide: event after edge 6, release by window.
      bus.coin5_raw = 1'b1;
      cyc(6);
      chk("t1_count_e6", fc(), 8'h00);
      cyc(1);
      chk("t1_count_e7", fc(), 8'h01);
      cyc(3);
      bus.coin5_raw = 1'b0;
      cyc(11);
      chk("t1_burst_e21", ba(), 8'h00);
      cyc(1);
      chk("t1_coin_e22", co(), 8'h00);
      chk("t1_burst_e22", ba(), 8'h00);
      cyc(1);
      chk("t1_coin_e23", co(), 8'h01);
      chk("t1_burst_e23", ba(), 8'h01);
      chk("t1_count_e23", fc(), 8'h00);
      cyc(1);
      chk("t1_coin_e24", co(), 8'h00);
      chk("t1_burst_e24", ba(), 8'h01);
      cyc(1);
      chk("t1_burst_e25", ba(), 8'h00);
      cyc(4);

      // 10 rs then 5 rs 8 cycles later: threshold release.
      bus.coin10_raw = 1'b1;
      cyc(6);
      bus.coin10_raw = 1'b0;
      cyc(2);
      bus.coin5_raw = 1'b1;
      cyc(6);
      chk("t2_count_e14", fc(), 8'h01);
      cyc(1);
      bus.coin5_raw = 1'b0;
      chk("t2_count_e15", fc(), 8'h02);
      chk("t2_coin_e15", co(), 8'h00);
      cyc(1);
      chk("t2_coin_e16", co(), 8'h02);
      chk("t2_burst_e16", ba(), 8'h01);
      cyc(1);
      chk("t2_coin_e17", co(), 8'h01);
      cyc(1);
      chk("t2_coin_e18", co(), 8'h00);
      chk("t2_burst_e18", ba(), 8'h01);
      cyc(1);
      chk("t2_burst_e19", ba(), 8'h00);
      cyc(10);

      // Three 5 rs coins 12 cycles apart: third one hits the threshold.
      for (int k = 0; k < 2; k++) begin
         bus.coin5_raw = 1'b1;
         cyc(5);
         bus.coin5_raw = 1'b0;
         cyc(7);
      end
      bus.coin5_raw = 1'b1;
      cyc(5);
      bus.coin5_raw = 1'b0;
      cyc(1);
      chk("t3_count_e30", fc(), 8'h02);
      chk("t3_burst_e30", ba(), 8'h00);
      cyc(1);
      chk("t3_count_e31", fc(), 8'h03);
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk("t3_coin_code", co(), 8'h01);
         chk("t3_burst_code", ba(), 8'h01);
      end
      chk("t3_count_e34", fc(), 8'h00);
      cyc(1);
      chk("t3_coin_term", co(), 8'h00);
      chk("t3_burst_term", ba(), 8'h01);
      cyc(1);
      chk("t3_burst_end", ba(), 8'h00);
      cyc(6);

      // Bounce: 1-cycle glitches every 3 cycles never debounce.
      for (int k = 0; k < 10; k++) begin
         bus.coin5_raw = 1'b1;
         cyc(1);
         bus.coin5_raw = 1'b0;
         cyc(2);
         chk("t4_reject", rj(), 8'h00);
         chk("t4_coin", co(), 8'h00);
      end
      cyc(20);
      chk("t4_count", fc(), 8'h00);
      chk("t4_burst", ba(), 8'h00);

      // Simultaneous events on both channels.
      bus.coin5_raw  = 1'b1;
      bus.coin10_raw = 1'b1;
      cyc(6);
      bus.coin5_raw  = 1'b0;
      bus.coin10_raw = 1'b0;
      chk("t5_reject_e6", rj(), 8'h00);
      cyc(1);
      chk("t5_reject_e7", rj(), 8'h01);
      chk("t5_count_e7", fc(), 8'h00);
      cyc(1);
      chk("t5_reject_e8", rj(), 8'h00);
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         chk("t5_no_burst", ba(), 8'h00);
      end
      chk("t5_count_end", fc(), 8'h00);

      // 10 rs released by window; a 5 rs event lands in the RELEASE cycle.
      bus.coin10_raw = 1'b1;
      cyc(6);
      bus.coin10_raw = 1'b0;
      cyc(10);
      bus.coin5_raw = 1'b1;
      cyc(6);
      bus.coin5_raw = 1'b0;
      chk("t6_coin_e22", co(), 8'h00);
      chk("t6_count_e22", fc(), 8'h01);
      chk("t6_reject_e22", rj(), 8'h00);
      cyc(1);
      chk("t6_coin_e23", co(), 8'h02);
      chk("t6_reject_e23", rj(), 8'h01);
      chk("t6_count_e23", fc(), 8'h00);
      cyc(1);
      chk("t6_coin_e24", co(), 8'h00);
      chk("t6_burst_e24", ba(), 8'h01);
      chk("t6_reject_e24", rj(), 8'h00);
      cyc(1);
      chk("t6_burst_e25", ba(), 8'h00);
      chk("t6_count_e25", fc(), 8'h00);
      cyc(8);

      // Reset in COLLECT discards the queued coin; no burst follows.
      bus.coin5_raw = 1'b1;
      cyc(6);
      bus.coin5_raw = 1'b0;
      cyc(2);
      chk("t7_count_pre", fc(), 8'h01);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("t7_count_rst", fc(), 8'h00);
      chk("t7_coin_rst", co(), 8'h00);
      for (int k = 0; k < 25; k++) begin
         cyc(1);
         chk("t7_no_burst", ba(), 8'h00);
         chk("t7_no_code", co(), 8'h00);
      end
      chk("t7_count_end", fc(), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
